// File: rtl/door_sequencer_if.sv
// rtl/door_sequencer_if.sv - door controller signal bundle between car controller and door drive
interface door_sequencer_if;
  logic       door_req;
  logic       car_moving;
  logic       open_btn;
  logic       close_btn;
  logic       obstruction;
  logic       weight_limit_exceeded;
  logic       motor_open;
  logic       motor_close;
  logic       door_is_open;
  logic       door_closed;
  logic       door_done;
  logic       move_permit;
  logic [1:0] reopen_count;
  logic       nudge;

  modport slave (
    input  door_req, car_moving, open_btn, close_btn, obstruction, weight_limit_exceeded,
    output motor_open, motor_close, door_is_open, door_closed, door_done, move_permit,
           reopen_count, nudge
  );

  modport master (
    output door_req, car_moving, open_btn, close_btn, obstruction, weight_limit_exceeded,
    input  motor_open, motor_close, door_is_open, door_closed, door_done, move_permit,
           reopen_count, nudge
  );
endinterface

// File: rtl/door_sequencer.sv
// rtl/door_sequencer.sv - cabin door open/hold/close sequencer with obstruction and overload interlock
// Optional nudge-close after repeated reopens is enabled by defining DOOR_NUDGE_EN.
module door_sequencer #(
  parameter int OPEN_TIME  = 4,
  parameter int HOLD_TIME  = 8,
  parameter int CLOSE_TIME = 4,
  parameter int MAX_REOPEN = 3,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  door_sequencer_if.slave  door
);

`ifdef DOOR_NUDGE_EN
  typedef enum logic [2:0] {S_CLOSED, S_OPENING, S_OPEN, S_CLOSING, S_NUDGE} state_t;
  localparam logic [CNT_W-1:0] L_NUDGE_LAST = CNT_W'(2 * CLOSE_TIME - 1);
`else
  typedef enum logic [2:0] {S_CLOSED, S_OPENING, S_OPEN, S_CLOSING} state_t;
`endif

  localparam logic [CNT_W-1:0] L_OPEN_LAST  = CNT_W'(OPEN_TIME - 1);
  localparam logic [CNT_W-1:0] L_HOLD_LAST  = CNT_W'(HOLD_TIME - 1);
  localparam logic [CNT_W-1:0] L_CLOSE_LAST = CNT_W'(CLOSE_TIME - 1);
  localparam int L_LONGEST = (OPEN_TIME > HOLD_TIME)
                           ? ((OPEN_TIME > 2 * CLOSE_TIME) ? OPEN_TIME : 2 * CLOSE_TIME)
                           : ((HOLD_TIME > 2 * CLOSE_TIME) ? HOLD_TIME : 2 * CLOSE_TIME);

  if (OPEN_TIME < 1 || HOLD_TIME < 1 || CLOSE_TIME < 1 || MAX_REOPEN < 1) begin : g_bad_time
    $error("door_sequencer: phase times and MAX_REOPEN must be >= 1");
  end
  if (CNT_W < 31 && (1 << CNT_W) <= L_LONGEST) begin : g_bad_width
    $error("door_sequencer: CNT_W too narrow for the longest phase");
  end

  state_t           r_state, w_state_next;
  logic [CNT_W-1:0] r_t, w_t_next;
  logic [1:0]       r_reopen, w_reopen_next;
  logic             r_done, w_done_next;
  logic             w_hold;
  logic             w_reopen_inc_sat;
  state_t           w_close_state;

  // Anything that keeps the door open in OPEN also forces a reopen in CLOSING.
  assign w_hold = door.open_btn | door.obstruction | door.weight_limit_exceeded;
  assign w_reopen_inc_sat = (r_reopen != 2'd3);

`ifdef DOOR_NUDGE_EN
  assign w_close_state = (int'(r_reopen) >= MAX_REOPEN) ? S_NUDGE : S_CLOSING;
`else
  assign w_close_state = S_CLOSING;
`endif

  always_comb begin
    w_state_next  = r_state;
    w_t_next      = r_t + 1'b1;
    w_reopen_next = r_reopen;
    w_done_next   = 1'b0;
    case (r_state)
      S_CLOSED: begin
        w_t_next = '0;
        if ((door.door_req | door.open_btn) & ~door.car_moving) w_state_next = S_OPENING;
      end
      S_OPENING: begin
        if (r_t == L_OPEN_LAST) w_state_next = S_OPEN;
      end
      S_OPEN: begin
        if (w_hold) w_t_next = '0;
        else if (door.close_btn || r_t == L_HOLD_LAST) w_state_next = w_close_state;
      end
      S_CLOSING: begin
        if (w_hold) begin
          w_state_next  = S_OPENING;
          w_reopen_next = r_reopen + {1'b0, w_reopen_inc_sat};
        end else if (r_t == L_CLOSE_LAST) begin
          w_state_next  = S_CLOSED;
          w_reopen_next = 2'd0;
          w_done_next   = 1'b1;
        end
      end
`ifdef DOOR_NUDGE_EN
      // Only overload can interrupt a nudge close; the count is already saturated here.
      S_NUDGE: begin
        if (door.weight_limit_exceeded) begin
          w_state_next = S_OPENING;
        end else if (r_t == L_NUDGE_LAST) begin
          w_state_next  = S_CLOSED;
          w_reopen_next = 2'd0;
          w_done_next   = 1'b1;
        end
      end
`endif
      default: w_state_next = S_CLOSED;
    endcase
    if (w_state_next != r_state) w_t_next = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_CLOSED;
      r_t      <= '0;
      r_reopen <= 2'd0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_t      <= w_t_next;
      r_reopen <= w_reopen_next;
      r_done   <= w_done_next;
    end
  end

  assign door.motor_open   = (r_state == S_OPENING);
  assign door.door_is_open = (r_state == S_OPEN);
  assign door.door_closed  = (r_state == S_CLOSED);
  assign door.door_done    = r_done;
  assign door.reopen_count = r_reopen;
  assign door.move_permit  = (r_state == S_CLOSED) & ~door.weight_limit_exceeded & ~door.door_req;
`ifdef DOOR_NUDGE_EN
  assign door.motor_close  = (r_state == S_CLOSING) | (r_state == S_NUDGE);
  assign door.nudge        = (r_state == S_NUDGE);
`else
  assign door.motor_close  = (r_state == S_CLOSING);
  assign door.nudge        = 1'b0;
`endif

endmodule

// File: tb/tb_door_sequencer.sv
// tb/tb_door_sequencer.sv - table-driven bench for door_sequencer with hand-written corner sequences
module tb_door_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  door_sequencer_if dif ();

  door_sequencer #(
    .OPEN_TIME (4),
    .HOLD_TIME (8),
    .CLOSE_TIME(4),
    .MAX_REOPEN(3),
    .CNT_W     (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .door(dif)
  );

  // Input bits: rst, door_req, car_moving, open_btn, close_btn, obstruction, weight
  localparam logic [6:0] I_NONE = 7'b0000000;
  localparam logic [6:0] I_RST  = 7'b1000000;
  localparam logic [6:0] I_REQ  = 7'b0100000;
  localparam logic [6:0] I_CAR  = 7'b0010000;
  localparam logic [6:0] I_OPB  = 7'b0001000;
  localparam logic [6:0] I_CLB  = 7'b0000100;
  localparam logic [6:0] I_OBS  = 7'b0000010;
  localparam logic [6:0] I_WT   = 7'b0000001;

  // Output bits: motor_open, motor_close, door_is_open, door_closed, door_done, move_permit, nudge, count[1:0]
  localparam logic [8:0] X_OPENING = 9'b1_0_0_0_0_0_0_00;
  localparam logic [8:0] X_CLOSING = 9'b0_1_0_0_0_0_0_00;
  localparam logic [8:0] X_OPEN    = 9'b0_0_1_0_0_0_0_00;
  localparam logic [8:0] X_CLOSED  = 9'b0_0_0_1_0_0_0_00;
  localparam logic [8:0] X_DONE    = 9'b0_0_0_0_1_0_0_00;
  localparam logic [8:0] X_PERMIT  = 9'b0_0_0_0_0_1_0_00;
  localparam logic [8:0] X_NUDGE   = 9'b0_1_0_0_0_0_1_00;
  localparam logic [8:0] C1        = 9'd1;
  localparam logic [8:0] C3        = 9'd3;

`ifdef DOOR_NUDGE_EN
  localparam int PASSES = 2;
`else
  localparam int PASSES = 1;
`endif

  typedef struct {
    logic [6:0] in;
    logic [8:0] exp;
    int         n;
    string      nm;
  } vec_t;

  vec_t       tbl[$];
  int         total = 0;
  int         bad = 0;
  logic [8:0] c;

  function automatic void add(input logic [6:0] in, input logic [8:0] exp, input int n, input string nm);
    vec_t v;
    v.in = in; v.exp = exp; v.n = n; v.nm = nm;
    tbl.push_back(v);
  endfunction

  task automatic step(input logic [6:0] in, input logic [8:0] exp, input string nm);
    logic [8:0] got;
    @(negedge clk);
    rst                       = in[6];
    dif.door_req              = in[5];
    dif.car_moving            = in[4];
    dif.open_btn              = in[3];
    dif.close_btn             = in[2];
    dif.obstruction           = in[1];
    dif.weight_limit_exceeded = in[0];
    #1;
    got = {dif.motor_open, dif.motor_close, dif.door_is_open, dif.door_closed, dif.door_done,
           dif.move_permit, dif.nudge, dif.reopen_count};
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s (check %0d): got=%b expected=%b", nm, total, got, exp);
    end
  endtask

  initial begin
    dif.door_req = 1'b0; dif.car_moving = 1'b0; dif.open_btn = 1'b0;
    dif.close_btn = 1'b0; dif.obstruction = 1'b0; dif.weight_limit_exceeded = 1'b0;

    // Basic cycle from a door_req pulse
    add(I_REQ,         X_CLOSED,                    1,  "t1 req pulse");
    add(I_NONE,        X_OPENING,                   4,  "t1 opening");
    add(I_NONE,        X_OPEN,                      8,  "t1 open");
    add(I_NONE,        X_CLOSING,                   4,  "t1 closing");
    add(I_NONE,        X_CLOSED | X_DONE | X_PERMIT, 1, "t1 done");
    add(I_NONE,        X_CLOSED | X_PERMIT,         1,  "t1 done clears");
    // Request blocked while the car moves
    add(I_REQ | I_CAR, X_CLOSED,                    10, "t2 car moving");
    add(I_REQ,         X_CLOSED,                    1,  "t2 car stops");
    add(I_NONE,        X_OPENING,                   4,  "t2 opening");
    // Overload holds the door open
    add(I_WT,          X_OPEN,                      20, "t3 overload hold");
    add(I_NONE,        X_OPEN,                      8,  "t3 hold after drop");
    add(I_NONE,        X_CLOSING,                   4,  "t3 closing");
    add(I_NONE,        X_CLOSED | X_DONE | X_PERMIT, 1, "t3 done");
    add(I_WT,          X_CLOSED,                    1,  "overload blocks permit");
    // Obstruction in the 3rd closing cycle
    add(I_OPB,         X_CLOSED | X_PERMIT,         1,  "t4 open_btn");
    add(I_NONE,        X_OPENING,                   4,  "t4 opening");
    add(I_NONE,        X_OPEN,                      8,  "t4 open");
    add(I_NONE,        X_CLOSING,                   2,  "t4 closing");
    add(I_OBS,         X_CLOSING,                   1,  "t4 obstruction");
    add(I_NONE,        X_OPENING | C1,              4,  "t4 reopening");
    add(I_NONE,        X_OPEN | C1,                 8,  "t4 reopen hold");
    add(I_NONE,        X_CLOSING | C1,              4,  "t4 clean close");
    add(I_NONE,        X_CLOSED | X_DONE | X_PERMIT, 1, "t4 done count clear");
    add(I_NONE,        X_CLOSED | X_PERMIT,         1,  "t4 single done");
    // door_req during closing is ignored; obstruction on the last closing cycle still reopens
    add(I_REQ,         X_CLOSED,                    1,  "last-cycle req");
    add(I_NONE,        X_OPENING,                   4,  "last-cycle opening");
    add(I_NONE,        X_OPEN,                      8,  "last-cycle open");
    add(I_REQ,         X_CLOSING,                   3,  "req while closing");
    add(I_OBS,         X_CLOSING,                   1,  "obstruction last cycle");
    add(I_NONE,        X_OPENING | C1,              4,  "last-cycle reopening");
    add(I_NONE,        X_OPEN | C1,                 8,  "last-cycle open again");
    add(I_NONE,        X_CLOSING | C1,              4,  "last-cycle closing");
    add(I_NONE,        X_CLOSED | X_DONE | X_PERMIT, 1, "last-cycle done");

    step(I_RST, X_CLOSED | X_PERMIT, "reset state");
    step(I_RST, X_CLOSED | X_PERMIT, "reset held");
    foreach (tbl[k]) begin
      for (int j = 0; j < tbl[k].n; j++) step(tbl[k].in, tbl[k].exp, tbl[k].nm);
    end

    // open_btn beats close_btn at t=2, and the hold timer restarts from that cycle
    step(I_REQ, X_CLOSED, "t5 req");
    repeat (4) step(I_NONE, X_OPENING, "t5 opening");
    repeat (2) step(I_NONE, X_OPEN, "t5 open t0-1");
    step(I_OPB | I_CLB, X_OPEN, "t5 both buttons");
    repeat (5) step(I_NONE, X_OPEN, "t5 timer restarted");
    step(I_CLB, X_OPEN, "t5 close_btn alone");
    step(I_NONE, X_CLOSING, "t5 closing after btn");
    step(I_OBS, X_CLOSING, "t5 reopen");
    step(I_RST, X_OPENING | C1, "rst mid opening");
    step(I_NONE, X_CLOSED | X_PERMIT, "after rst abort");

    // Repeated reopens saturate the count; with nudge enabled the 4th close is a nudge close
    for (int pass = 0; pass < PASSES; pass++) begin
      step(I_REQ, X_CLOSED, "sat req");
      for (int r = 0; r < 5; r++) begin
        c = (r > 3) ? C3 : 9'(r);
        repeat (4) step(I_NONE, X_OPENING | c, "sat opening");
        repeat (8) step(I_NONE, X_OPEN | c, "sat open");
`ifdef DOOR_NUDGE_EN
        if (r == 3) break;
`endif
        if (r == 4) break;
        step(I_OBS, X_CLOSING | c, "sat reopen");
      end
`ifdef DOOR_NUDGE_EN
      if (pass == 0) begin
        repeat (8) step(I_OBS, X_NUDGE | C3, "nudge ignores obstruction");
        step(I_OBS, X_CLOSED | X_DONE | X_PERMIT, "nudge done");
      end else begin
        repeat (3) step(I_OBS, X_NUDGE | C3, "nudge before rst");
        step(I_RST, X_NUDGE | C3, "rst mid nudge");
        step(I_NONE, X_CLOSED | X_PERMIT, "after nudge rst");
      end
`else
      repeat (4) step(I_NONE, X_CLOSING | C3, "sat close");
      step(I_NONE, X_CLOSED | X_DONE | X_PERMIT, "sat done");
`endif
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
